// File: rtl/ones_pattern_pkg.sv
// Shared types and helpers for the constant-weight pattern enumerator.
// Optional pat_index output is enabled by defining ONES_PATTERN_INDEX_EN.
package ones_pattern_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam int MAX_W = 16;

  // Lowest word of weight n: n ones packed at the LSB end (n=0 gives 0).
  function automatic logic [MAX_W-1:0] first_pattern(input int unsigned n);
    logic [MAX_W:0] wide;
    wide = (17'(1) << n) - 17'(1);
    return wide[MAX_W-1:0];
  endfunction

  // Highest w-bit word of weight n: n ones packed at the MSB end.
  function automatic logic [MAX_W-1:0] last_pattern(input int unsigned n,
                                                    input int unsigned w);
    return first_pattern(n) << (w - n);
  endfunction

  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // Enough bits to rank every word of the widest weight class, C(w, w/2).
  function automatic int index_width(input int w);
    return $clog2(binom(w, w / 2));
  endfunction

  localparam int INDEX_W = index_width(8);

endpackage

// File: rtl/next_combination.sv
// Gosper step: maps a WIDTH-bit word to the next larger word of equal popcount.
module next_combination #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] next
);

  localparam int TZ_W = $clog2(WIDTH);

  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] ripple;
  logic [TZ_W-1:0]  tz;

  always_comb begin
    lowest = x & (-x);
    ripple = x + lowest;
    // Scan from the MSB down so the last hit is the lowest set bit.
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) tz = TZ_W'(i);
    end
    next = ripple | (((ripple ^ x) >> 2) >> tz);
  end

endmodule

// File: rtl/ones_pattern_enum.sv
// Enumerates every WIDTH-bit word of popcount N in ascending order, one per cycle.
// Define ONES_PATTERN_INDEX_EN to add the pat_index (lexicographic rank) output.
module ones_pattern_enum
  import ones_pattern_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int CNT_W   = $clog2(WIDTH + 1),
  localparam int INDEX_W = index_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt_valid,
  output logic               cnt_ready,
  input  logic [CNT_W-1:0]   cnt_in,
  output logic               pat_valid,
  input  logic               pat_ready,
  output logic [WIDTH-1:0]   pat_data,
  output logic               pat_last,
`ifdef ONES_PATTERN_INDEX_EN
  output logic [INDEX_W-1:0] pat_index,
`endif
  output logic               err
);

  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] n_q;
  logic [WIDTH-1:0] next;
  logic             accept;

  next_combination #(.WIDTH(WIDTH)) u_next (
    .x    (pat_data),
    .next (next)
  );

  assign accept = cnt_valid && cnt_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_ready <= 1'b1;
      pat_valid <= 1'b0;
      pat_data  <= '0;
      pat_last  <= 1'b0;
      err       <= 1'b0;
      n_q       <= '0;
`ifdef ONES_PATTERN_INDEX_EN
      pat_index <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          // Re-arming one cycle after entry gives the bubble after a sequence.
          cnt_ready <= 1'b1;
          if (accept) begin
            if (cnt_in > N_MAX) begin
              err <= 1'b1;
            end else begin
              n_q       <= cnt_in;
              pat_data  <= WIDTH'(first_pattern(int'(cnt_in)));
              pat_valid <= 1'b1;
              pat_last  <= (cnt_in == '0) || (cnt_in == N_MAX);
              cnt_ready <= 1'b0;
              state     <= EMIT;
`ifdef ONES_PATTERN_INDEX_EN
              pat_index <= '0;
`endif
            end
          end
        end
        EMIT: begin
          if (pat_ready) begin
            if (pat_last) begin
              pat_valid <= 1'b0;
              pat_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              pat_data <= next;
              pat_last <= (next == WIDTH'(last_pattern(int'(n_q), WIDTH)));
`ifdef ONES_PATTERN_INDEX_EN
              pat_index <= pat_index + 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_pattern_enum.sv
// Self-checking bench for ones_pattern_enum against a brute-force popcount model.
module tb_ones_pattern_enum;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cnt_valid;
  logic             cnt_ready;
  logic [CNT_W-1:0] cnt_in;
  logic             pat_valid;
  logic             pat_ready;
  logic [WIDTH-1:0] pat_data;
  logic             pat_last;
  logic             err;
`ifdef ONES_PATTERN_INDEX_EN
  logic [6:0]       pat_index;
`endif

  int vectors     = 0;
  int miscompares = 0;

  ones_pattern_enum #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .cnt_in    (cnt_in),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .pat_last  (pat_last),
`ifdef ONES_PATTERN_INDEX_EN
    .pat_index (pat_index),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected sequence: every word of weight n, in ascending numeric order.
  task automatic build_model(input int n, output logic [WIDTH-1:0] q[$]);
    q = {};
    for (int v = 0; v < (1 << WIDTH); v++) begin
      if ($countones(v) == n) q.push_back(WIDTH'(v));
    end
  endtask

  task automatic request(input int n);
    cnt_in    = CNT_W'(n);
    cnt_valid = 1'b1;
    check("req_cnt_ready", 32'(cnt_ready), 32'd1);
    step();
    cnt_valid = 1'b0;
    cnt_in    = CNT_W'($urandom);
  endtask

  // Drains one sequence; abort_at > 0 stops the loop after that many handshakes.
  task automatic run_seq(input int n, input bit rand_ready, input int abort_at);
    logic [WIDTH-1:0] q[$];
    int idx;
    int cyc;
    int budget;
    bit rdy;
    build_model(n, q);
    idx    = 0;
    cyc    = 0;
    budget = q.size() * 20 + 50;
    request(n);
    while (idx < q.size() && cyc < budget) begin
      rdy       = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pat_ready = rdy;
      cnt_valid = (idx == q.size() - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      cnt_in    = CNT_W'($urandom);
      check("pat_valid", 32'(pat_valid), 32'd1);
      check("pat_data", 32'(pat_data), 32'(q[idx]));
      check("pat_last", 32'(pat_last), 32'(idx == q.size() - 1));
      check("err_in_emit", 32'(err), 32'd0);
      check("cnt_ready_in_emit", 32'(cnt_ready), 32'd0);
`ifdef ONES_PATTERN_INDEX_EN
      check("pat_index", 32'(pat_index), 32'(idx));
`endif
      step();
      cyc++;
      if (rdy) idx++;
      if (abort_at > 0 && idx == abort_at) break;
    end
    if (cyc >= budget) check("timeout", 32'(idx), 32'(q.size()));
    if (abort_at == 0) begin
      // Bubble: request still offered but must not be taken.
      pat_ready = 1'($urandom_range(0, 1));
      check("post_valid", 32'(pat_valid), 32'd0);
      check("post_ready_bubble", 32'(cnt_ready), 32'd0);
      step();
      check("post_ready_back", 32'(cnt_ready), 32'd1);
      check("post_no_accept", 32'(pat_valid), 32'd0);
      check("post_err", 32'(err), 32'd0);
      cnt_valid = 1'b0;
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    cnt_valid = 1'b0;
    cnt_in    = '0;
    pat_ready = 1'b0;
    step();
    step();
    check("rst_cnt_ready", 32'(cnt_ready), 32'd1);
    check("rst_pat_valid", 32'(pat_valid), 32'd0);
    check("rst_pat_data", 32'(pat_data), 32'd0);
    check("rst_pat_last", 32'(pat_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    run_seq(3, 1'b0, 0);
    run_seq(0, 1'b0, 0);
    run_seq(8, 1'b0, 0);

    // Out-of-range requests: a single err pulse and nothing emitted.
    for (int k = 9; k <= 15; k += 6) begin
      request(k);
      check("err_pulse", 32'(err), 32'd1);
      check("err_cnt_ready", 32'(cnt_ready), 32'd1);
      check("err_no_valid", 32'(pat_valid), 32'd0);
      for (int j = 0; j < 3; j++) begin
        step();
        check("err_cleared", 32'(err), 32'd0);
        check("err_still_no_valid", 32'(pat_valid), 32'd0);
        check("err_ready_held", 32'(cnt_ready), 32'd1);
      end
    end

    run_seq(1, 1'b1, 0);

    // Reset mid-sequence after the 10th handshake.
    run_seq(4, 1'b0, 10);
    rst       = 1'b1;
    pat_ready = 1'b1;
    step();
    rst = 1'b0;
    check("abort_pat_valid", 32'(pat_valid), 32'd0);
    check("abort_pat_data", 32'(pat_data), 32'd0);
    check("abort_pat_last", 32'(pat_last), 32'd0);
    check("abort_cnt_ready", 32'(cnt_ready), 32'd1);
    run_seq(2, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      run_seq(int'($urandom_range(0, WIDTH)), 1'b1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
